calc_tag_tracker: RTL and testbench

Parametrised outstanding-request tracker for the CALC request/response ports. It sits beside the calculator core and watches every request port and its matching output port. Per port it keeps the set of in-flight tags and an age counter for each tag. It reports protocol errors (duplicate tag issue, orphan response, response timeout) through a registered error channel and a saturating error counter. It generalises the fixed 4-port / 2-bit-tag CALC-3 arrangement to any port count, tag width and timeout.

---
 rtl/calc_tag_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_calc_tag_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_tag_tracker.sv
// calc_tag_tracker
//   Outstanding-request tracker for the CALC request/response ports. Keeps a
//   per-port set of in-flight tags with an age counter per tag, and reports
//   duplicate issues, orphan responses and response timeouts.
//
// Ports
//   c_clk      in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   req_cmd    in   NPORTS*4      per-port request command, non-zero = issue
//   req_tag    in   NPORTS*TAG_W  tag of the issued request
//   out_resp   in   NPORTS*2      per-port response code, non-zero = response
//   out_tag    in   NPORTS*TAG_W  tag of the response
//   tmo_en     in   enable timeout checking
//   clr_err    in   synchronous clear of err_count and lost_err
//   tag_busy   out  in-flight bitmap, bit p*2**TAG_W+t = port p tag t
//   idle       out  no tag in flight on any port
//   err_valid  out  one-cycle error pulse
//   err_port   out  port of the reported error
//   err_tag    out  tag of the reported error
//   err_code   out  1 = duplicate, 2 = orphan, 3 = timeout
//   err_count  out  saturating count of cycles with at least one error
//   lost_err   out  sticky, set when a cycle carried more than one error

module calc_tag_tracker #(
    parameter int unsigned NPORTS     = 4,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned TMO_CYCLES = 64,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned NTAGS     = 2 ** TAG_W,
    localparam int unsigned PORT_W    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                    c_clk,
    input  logic                    reset,
    input  logic [NPORTS*4-1:0]     req_cmd,
    input  logic [NPORTS*TAG_W-1:0] req_tag,
    input  logic [NPORTS*2-1:0]     out_resp,
    input  logic [NPORTS*TAG_W-1:0] out_tag,
    input  logic                    tmo_en,
    input  logic                    clr_err,
    output logic [NPORTS*NTAGS-1:0] tag_busy,
    output logic                    idle,
    output logic                    err_valid,
    output logic [PORT_W-1:0]       err_port,
    output logic [TAG_W-1:0]        err_tag,
    output logic [1:0]              err_code,
    output logic [CNT_W-1:0]        err_count,
    output logic                    lost_err
);

    localparam int unsigned NENT  = NPORTS * NTAGS;
    localparam int unsigned AGE_W = $clog2(TMO_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(TMO_CYCLES);
    // The stored age lags the edge count by one, so an entry whose age will
    // reach TMO_CYCLES-1 at this edge currently holds TMO_CYCLES-2.
    localparam logic [AGE_W-1:0] AGE_FIRE = AGE_W'(TMO_CYCLES - 2);

    logic [NENT-1:0]  busy_q, busy_d;
    logic [AGE_W-1:0] age_q [NENT];
    logic [AGE_W-1:0] age_d [NENT];

    logic [NENT-1:0] orph_ev, dup_ev, tmo_ev;

    logic              any_evt, multi_evt;
    logic [PORT_W-1:0] win_port;
    logic [TAG_W-1:0]  win_tag;
    logic [1:0]        win_code;

    logic              err_valid_q;
    logic [PORT_W-1:0] err_port_q;
    logic [TAG_W-1:0]  err_tag_q;
    logic [1:0]        err_code_q;
    logic [CNT_W-1:0]  err_count_q;
    logic              lost_err_q;

    // Per-entry next state and event detection
    always_comb begin
        busy_d  = busy_q;
        orph_ev = '0;
        dup_ev  = '0;
        tmo_ev  = '0;
        for (int i = 0; i < int'(NENT); i++) begin
            age_d[i] = age_q[i];
        end
        for (int p = 0; p < int'(NPORTS); p++) begin
            for (int t = 0; t < int'(NTAGS); t++) begin
                automatic int  i   = p * int'(NTAGS) + t;
                automatic logic iss = (|req_cmd[p*4 +: 4]) &&
                                      (req_tag[p*TAG_W +: TAG_W] == TAG_W'(t));
                automatic logic rsp = (|out_resp[p*2 +: 2]) &&
                                      (out_tag[p*TAG_W +: TAG_W] == TAG_W'(t));
                automatic logic b   = busy_q[i];
                automatic logic tmo = tmo_en && b && !rsp && !iss &&
                                      (age_q[i] >= AGE_FIRE);
                orph_ev[i] = rsp && !b;
                dup_ev[i]  = iss && b && !rsp;
                tmo_ev[i]  = tmo;
                busy_d[i]  = iss || (b && !rsp && !tmo);
                if (iss || !busy_d[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_SAT) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    // Event count and report arbitration. Candidates are visited from lowest
    // to highest priority so the last assignment is the winner.
    always_comb begin
        any_evt   = 1'b0;
        multi_evt = 1'b0;
        win_port  = '0;
        win_tag   = '0;
        win_code  = 2'd0;
        for (int i = 0; i < int'(NENT); i++) begin
            if (orph_ev[i]) begin
                multi_evt = multi_evt | any_evt;
                any_evt   = 1'b1;
            end
            if (dup_ev[i]) begin
                multi_evt = multi_evt | any_evt;
                any_evt   = 1'b1;
            end
            if (tmo_ev[i]) begin
                multi_evt = multi_evt | any_evt;
                any_evt   = 1'b1;
            end
        end
        for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
            for (int t = int'(NTAGS) - 1; t >= 0; t--) begin
                if (tmo_ev[p*int'(NTAGS)+t]) begin
                    win_port = PORT_W'(p);
                    win_tag  = TAG_W'(t);
                    win_code = 2'd3;
                end
            end
            for (int t = int'(NTAGS) - 1; t >= 0; t--) begin
                if (dup_ev[p*int'(NTAGS)+t]) begin
                    win_port = PORT_W'(p);
                    win_tag  = TAG_W'(t);
                    win_code = 2'd1;
                end
            end
            for (int t = int'(NTAGS) - 1; t >= 0; t--) begin
                if (orph_ev[p*int'(NTAGS)+t]) begin
                    win_port = PORT_W'(p);
                    win_tag  = TAG_W'(t);
                    win_code = 2'd2;
                end
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            err_valid_q <= 1'b0;
            err_port_q  <= '0;
            err_tag_q   <= '0;
            err_code_q  <= 2'd0;
            err_count_q <= '0;
            lost_err_q  <= 1'b0;
            for (int i = 0; i < int'(NENT); i++) begin
                age_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            err_valid_q <= any_evt;
            for (int i = 0; i < int'(NENT); i++) begin
                age_q[i] <= age_d[i];
            end
            if (any_evt) begin
                err_port_q <= win_port;
                err_tag_q  <= win_tag;
                err_code_q <= win_code;
            end
            // Clear beats a same-cycle increment
            if (clr_err) begin
                err_count_q <= '0;
                lost_err_q  <= 1'b0;
            end else begin
                if (any_evt && !(&err_count_q)) begin
                    err_count_q <= err_count_q + CNT_W'(1);
                end
                if (multi_evt) begin
                    lost_err_q <= 1'b1;
                end
            end
        end
    end

    assign tag_busy  = busy_q;
    assign idle      = ~|busy_q;
    assign err_valid = err_valid_q;
    assign err_port  = err_port_q;
    assign err_tag   = err_tag_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
    assign lost_err  = lost_err_q;

endmodule

// File: tb/tb_calc_tag_tracker.sv
// Bench for calc_tag_tracker: 4 ports, 2-bit tags, timeout of 8 cycles.
module tb_calc_tag_tracker;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [15:0] req_cmd;
    logic [7:0]  req_tag;
    logic [7:0]  out_resp;
    logic [7:0]  out_tag;
    logic        tmo_en;
    logic        clr_err;
    logic [15:0] tag_busy;
    logic        idle;
    logic        err_valid;
    logic [1:0]  err_port;
    logic [1:0]  err_tag;
    logic [1:0]  err_code;
    logic [15:0] err_count;
    logic        lost_err;

    int total = 0;
    int bad   = 0;

    calc_tag_tracker #(
        .NPORTS     (4),
        .TAG_W      (2),
        .TMO_CYCLES (8),
        .CNT_W      (16)
    ) dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .req_cmd   (req_cmd),
        .req_tag   (req_tag),
        .out_resp  (out_resp),
        .out_tag   (out_tag),
        .tmo_en    (tmo_en),
        .clr_err   (clr_err),
        .tag_busy  (tag_busy),
        .idle      (idle),
        .err_valid (err_valid),
        .err_port  (err_port),
        .err_tag   (err_tag),
        .err_code  (err_code),
        .err_count (err_count),
        .lost_err  (lost_err)
    );

    always #5 c_clk = ~c_clk;

    typedef struct packed {
        logic [15:0] cmd;
        logic [7:0]  rtag;
        logic [7:0]  resp;
        logic [7:0]  otag;
        logic        tmo;
        logic        clr;
        logic [15:0] busy;
        logic        ev;
        logic [1:0]  port;
        logic [1:0]  tag;
        logic [1:0]  code;
        logic [15:0] cnt;
        logic        lost;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[14];

    // Running expectation for held error fields and counter in hand sequences
    logic [1:0]  hp, ht, hc;
    logic [15:0] ec;

    function automatic vec_t mkv(input logic [15:0] cmd, input logic [7:0] rtag,
                                 input logic [7:0] resp, input logic [7:0] otag,
                                 input logic tmo, input logic clr, input logic [15:0] busy,
                                 input logic ev, input logic [1:0] port, input logic [1:0] tag,
                                 input logic [1:0] code, input logic [15:0] cnt,
                                 input logic lost);
        vec_t v;
        v.cmd = cmd;   v.rtag = rtag; v.resp = resp; v.otag = otag;
        v.tmo = tmo;   v.clr = clr;   v.busy = busy; v.ev = ev;
        v.port = port; v.tag = tag;   v.code = code; v.cnt = cnt; v.lost = lost;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic run_row(input vec_t v, input string label);
        vec_t e;
        req_cmd  = v.cmd;
        req_tag  = v.rtag;
        out_resp = v.resp;
        out_tag  = v.otag;
        tmo_en   = v.tmo;
        clr_err  = v.clr;
        exp_q.push_back(v);
        @(posedge c_clk);
        #1;
        e = exp_q.pop_front();
        chk({label, " busy"}, 32'(tag_busy), 32'(e.busy));
        chk({label, " idle"}, 32'(idle), 32'(e.busy == 16'h0));
        chk({label, " err_valid"}, 32'(err_valid), 32'(e.ev));
        chk({label, " err_port"}, 32'(err_port), 32'(e.port));
        chk({label, " err_tag"}, 32'(err_tag), 32'(e.tag));
        chk({label, " err_code"}, 32'(err_code), 32'(e.code));
        chk({label, " err_count"}, 32'(err_count), 32'(e.cnt));
        chk({label, " lost_err"}, 32'(lost_err), 32'(e.lost));
    endtask

    task automatic wait_row(input logic [15:0] busy, input logic tmo, input string label);
        run_row(mkv(16'h0, 8'h0, 8'h0, 8'h0, tmo, 1'b0, busy, 1'b0, hp, ht, hc, ec, 1'b0),
                label);
    endtask

    task automatic issue_p2t3(input logic tmo, input string label);
        run_row(mkv(16'h0100, 8'h30, 8'h0, 8'h0, tmo, 1'b0, 16'h0800, 1'b0, hp, ht, hc, ec,
                    1'b0), label);
    endtask

    initial begin
        reset    = 1'b1;
        req_cmd  = '0;
        req_tag  = '0;
        out_resp = '0;
        out_tag  = '0;
        tmo_en   = 1'b1;
        clr_err  = 1'b0;

        //           cmd       rtag   resp   otag  tmo clr busy      ev port tag code cnt lost
        tbl[0]  = mkv(16'h0001, 8'h02, 8'h00, 8'h00, 1, 0, 16'h0004, 0, 0, 0, 0, 16'd0, 0);
        tbl[1]  = mkv(16'h0000, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0004, 0, 0, 0, 0, 16'd0, 0);
        tbl[2]  = mkv(16'h0000, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0004, 0, 0, 0, 0, 16'd0, 0);
        tbl[3]  = mkv(16'h0000, 8'h00, 8'h01, 8'h02, 1, 0, 16'h0000, 0, 0, 0, 0, 16'd0, 0);
        tbl[4]  = mkv(16'h0010, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0010, 0, 0, 0, 0, 16'd0, 0);
        tbl[5]  = mkv(16'h0000, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0010, 0, 0, 0, 0, 16'd0, 0);
        tbl[6]  = mkv(16'h0010, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0010, 1, 1, 0, 1, 16'd1, 0);
        tbl[7]  = mkv(16'h0000, 8'h00, 8'h04, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 1, 16'd1, 0);
        tbl[8]  = mkv(16'h0000, 8'h00, 8'h80, 8'h40, 1, 0, 16'h0000, 1, 3, 1, 2, 16'd2, 0);
        tbl[9]  = mkv(16'h0010, 8'h04, 8'h00, 8'h00, 1, 0, 16'h0020, 0, 3, 1, 2, 16'd2, 0);
        tbl[10] = mkv(16'h0010, 8'h04, 8'h11, 8'h03, 1, 0, 16'h0020, 1, 0, 3, 2, 16'd3, 1);
        tbl[11] = mkv(16'h0000, 8'h00, 8'h04, 8'h04, 1, 1, 16'h0000, 0, 0, 3, 2, 16'd0, 0);
        tbl[12] = mkv(16'h0000, 8'h00, 8'h10, 8'h20, 1, 1, 16'h0000, 1, 2, 2, 2, 16'd0, 0);
        tbl[13] = mkv(16'h0000, 8'h00, 8'h01, 8'h00, 1, 0, 16'h0000, 1, 0, 0, 2, 16'd1, 0);

        #12;
        chk("reset busy", 32'(tag_busy), 32'h0);
        chk("reset idle", 32'(idle), 32'h1);
        chk("reset err_valid", 32'(err_valid), 32'h0);
        chk("reset err_count", 32'(err_count), 32'h0);
        chk("reset lost_err", 32'(lost_err), 32'h0);
        #1 reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

        hp = 2'd0; ht = 2'd0; hc = 2'd2; ec = 16'd1;

        // Timeout fires at the 7th edge after issue
        issue_p2t3(1'b1, "tmoA issue");
        for (int k = 1; k <= 6; k++) wait_row(16'h0800, 1'b1, $sformatf("tmoA wait%0d", k));
        ec = ec + 1; hp = 2'd2; ht = 2'd3; hc = 2'd3;
        run_row(mkv(16'h0, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0, 16'h0, 1'b1, hp, ht, hc, ec, 1'b0),
                "tmoA fire");
        wait_row(16'h0, 1'b1, "tmoA after");

        // Response on the 7th edge retires cleanly
        issue_p2t3(1'b1, "tmoB issue");
        for (int k = 1; k <= 6; k++) wait_row(16'h0800, 1'b1, $sformatf("tmoB wait%0d", k));
        run_row(mkv(16'h0, 8'h0, 8'h10, 8'h30, 1'b1, 1'b0, 16'h0, 1'b0, hp, ht, hc, ec, 1'b0),
                "tmoB resp");
        wait_row(16'h0, 1'b1, "tmoB after");

        // Response on the 8th edge is an orphan after the timeout
        issue_p2t3(1'b1, "tmoC issue");
        for (int k = 1; k <= 6; k++) wait_row(16'h0800, 1'b1, $sformatf("tmoC wait%0d", k));
        ec = ec + 1;
        run_row(mkv(16'h0, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0, 16'h0, 1'b1, hp, ht, hc, ec, 1'b0),
                "tmoC fire");
        ec = ec + 1; hc = 2'd2;
        run_row(mkv(16'h0, 8'h0, 8'h10, 8'h30, 1'b1, 1'b0, 16'h0, 1'b1, hp, ht, hc, ec, 1'b0),
                "tmoC orphan");

        // Timeout disabled: ages saturate, then fire as soon as enabled
        issue_p2t3(1'b0, "tmoD issue");
        for (int k = 1; k <= 10; k++) wait_row(16'h0800, 1'b0, $sformatf("tmoD wait%0d", k));
        ec = ec + 1; hc = 2'd3;
        run_row(mkv(16'h0, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0, 16'h0, 1'b1, hp, ht, hc, ec, 1'b0),
                "tmoD enable");

        // Fill every tag on every port, then reset mid-cycle
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  kt;
            logic [15:0] fill;
            kt   = 2'(k);
            fill = 16'h0;
            for (int j = 0; j <= k; j++) fill = fill | (16'h1111 << j);
            run_row(mkv(16'h1111, {4{kt}}, 8'h0, 8'h0, 1'b1, 1'b0, fill, 1'b0, hp, ht, hc, ec,
                        1'b0), $sformatf("fill%0d", k));
        end
        req_cmd = '0;
        req_tag = '0;
        #2 reset = 1'b1;
        #1;
        chk("midreset busy", 32'(tag_busy), 32'h0);
        chk("midreset idle", 32'(idle), 32'h1);
        chk("midreset err_valid", 32'(err_valid), 32'h0);
        chk("midreset err_port", 32'(err_port), 32'h0);
        chk("midreset err_code", 32'(err_code), 32'h0);
        chk("midreset err_count", 32'(err_count), 32'h0);
        #4 reset = 1'b0;
        hp = 2'd0; ht = 2'd0; hc = 2'd0; ec = 16'd0;
        for (int k = 0; k < 3; k++) wait_row(16'h0, 1'b1, $sformatf("postreset%0d", k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
